// File: rtl/sercomp_pkg.sv
// Shared types and defaults for the multi-lane serial two's-complement negator.
package sercomp_pkg;

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } lane_state_t;

  localparam int unsigned SERCOMP_WORD_W = 8;
  localparam int unsigned SERCOMP_NCH    = 4;

  // Counter width that never collapses to zero bits for tiny word lengths.
  function automatic int unsigned sercomp_cnt_w(input int unsigned word_w);
    return (word_w <= 2) ? 1 : $clog2(word_w);
  endfunction

endpackage

// File: rtl/sercomp_lane.sv
// One lane: copy/invert FSM, bit counter, word framing and overflow detect.
// Optional SERCOMP_PAR_OUT_EN adds a shadow register and parallel word output.
module sercomp_lane
  import sercomp_pkg::*;
#(
  parameter int unsigned WORD_W = SERCOMP_WORD_W,
  parameter int unsigned CNT_W  = sercomp_cnt_w(SERCOMP_WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic              bit_i,
  input  logic              sow_i,
  input  logic              neg_mode_i,
  output logic              vld_o,
  output logic              bit_o,
  output logic              eow_o,
  output logic              ovf_o
`ifdef SERCOMP_PAR_OUT_EN
  ,
  output logic [WORD_W-1:0] par_word_o,
  output logic              par_vld_o
`endif
);

  lane_state_t      state_q, state_d, state_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d, mode_eff;
  logic             out_vld_q, out_bit_q, out_bit_d;
  logic             eow_q, eow_d, ovf_q, ovf_d;
  logic             first, last;

  // sow overrides the terminal count, so a realigned bit never closes a word.
  assign first     = (cnt_q == '0) || sow_i;
  assign last      = !sow_i && (cnt_q == CNT_W'(WORD_W - 1));
  assign mode_eff  = first ? neg_mode_i : mode_q;
  assign state_eff = first ? COPY : state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    out_bit_d = out_bit_q;
    eow_d     = eow_q;
    ovf_d     = ovf_q;
    if (vld_i) begin
      mode_d    = mode_eff;
      out_bit_d = (mode_eff && state_eff == INVERT) ? ~bit_i : bit_i;
      eow_d     = last;
      // Still in COPY at the MSB with a 1 means the word was 100..0.
      ovf_d     = last && mode_eff && state_eff == COPY && bit_i;
      if (last) begin
        state_d = COPY;
        cnt_d   = '0;
      end else begin
        state_d = (mode_eff && state_eff == COPY && bit_i) ? INVERT : state_eff;
        cnt_d   = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= COPY;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      out_vld_q <= 1'b0;
      out_bit_q <= 1'b0;
      eow_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      out_vld_q <= vld_i;
      out_bit_q <= out_bit_d;
      eow_q     <= eow_d;
      ovf_q     <= ovf_d;
    end
  end

  assign vld_o = out_vld_q;
  assign bit_o = out_bit_q;
  assign eow_o = eow_q;
  assign ovf_o = ovf_q;

`ifdef SERCOMP_PAR_OUT_EN
  logic [WORD_W-1:0] shadow_q, shadow_d, par_word_q, par_word_d;
  logic              par_vld_q, par_vld_d;

  always_comb begin
    shadow_d   = shadow_q;
    par_word_d = par_word_q;
    par_vld_d  = 1'b0;
    if (vld_i) begin
      shadow_d = {out_bit_d, shadow_q[WORD_W-1:1]};
      if (last) begin
        par_word_d = shadow_d;
        par_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q   <= '0;
      par_word_q <= '0;
      par_vld_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      par_word_q <= par_word_d;
      par_vld_q  <= par_vld_d;
    end
  end

  assign par_word_o = par_word_q;
  assign par_vld_o  = par_vld_q;
`endif

endmodule

// File: rtl/serial_twos_comp_nch.sv
// Multi-lane word-framed serial two's-complement negator (LSB first).
// Define SERCOMP_PAR_OUT_EN to add par_word/par_vld parallel outputs.
module serial_twos_comp_nch
  import sercomp_pkg::*;
#(
  parameter int unsigned WORD_W = SERCOMP_WORD_W,
  parameter int unsigned NCH    = SERCOMP_NCH
) (
  input  logic                  t_clk,
  input  logic                  r,
  input  logic [NCH-1:0]        in_vld,
  input  logic [NCH-1:0]        in_bit,
  input  logic [NCH-1:0]        in_sow,
  input  logic [NCH-1:0]        neg_mode,
  output logic [NCH-1:0]        out_vld,
  output logic [NCH-1:0]        out_bit,
  output logic [NCH-1:0]        out_eow,
  output logic [NCH-1:0]        ovf
`ifdef SERCOMP_PAR_OUT_EN
  ,
  output logic [NCH*WORD_W-1:0] par_word,
  output logic [NCH-1:0]        par_vld
`endif
);

  localparam int unsigned CNT_W = sercomp_cnt_w(WORD_W);

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    sercomp_lane #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk_i      (t_clk),
      .rst_ni     (r),
      .vld_i      (in_vld[g]),
      .bit_i      (in_bit[g]),
      .sow_i      (in_sow[g]),
      .neg_mode_i (neg_mode[g]),
      .vld_o      (out_vld[g]),
      .bit_o      (out_bit[g]),
      .eow_o      (out_eow[g]),
      .ovf_o      (ovf[g])
`ifdef SERCOMP_PAR_OUT_EN
      ,
      .par_word_o (par_word[g*WORD_W +: WORD_W]),
      .par_vld_o  (par_vld[g])
`endif
    );
  end

endmodule

// File: tb/tb_serial_twos_comp_nch.sv
// Self-checking bench: directed word scenarios plus random traffic vs. an arithmetic model.
module tb_serial_twos_comp_nch;

  localparam int unsigned W   = 8;
  localparam int unsigned NCH = 4;

  logic           t_clk = 1'b0;
  logic           r;
  logic [NCH-1:0] in_vld, in_bit, in_sow, neg_mode;
  logic [NCH-1:0] out_vld, out_bit, out_eow, ovf;
`ifdef SERCOMP_PAR_OUT_EN
  logic [NCH*W-1:0] par_word;
  logic [NCH-1:0]   par_vld;
`endif

  serial_twos_comp_nch #(
    .WORD_W (W),
    .NCH    (NCH)
  ) dut (
    .t_clk    (t_clk),
    .r        (r),
    .in_vld   (in_vld),
    .in_bit   (in_bit),
    .in_sow   (in_sow),
    .neg_mode (neg_mode),
    .out_vld  (out_vld),
    .out_bit  (out_bit),
    .out_eow  (out_eow),
    .ovf      (ovf)
`ifdef SERCOMP_PAR_OUT_EN
    ,
    .par_word (par_word),
    .par_vld  (par_vld)
`endif
  );

  always #5 t_clk = ~t_clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: bit position within word, bits received so far, latched mode.
  int              mk[NCH];
  longint unsigned mp[NCH];
  logic            mmode[NCH];
  logic [W-1:0]    obs[NCH];
  logic [W-1:0]    last_word[NCH];
  logic            last_ovf[NCH];
  int unsigned     eow_cnt[NCH];

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NCH; l++) begin
      mk[l] = 0;
      mp[l] = 0;
      mmode[l] = 1'b0;
    end
  endtask

  // Low bits of -x depend only on the low bits of x, so bit k of the
  // negated partial word is final as soon as bit k arrives.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] s, input logic [NCH-1:0] m);
    longint unsigned nv;
    logic eb, ee, eo;
    in_vld = v; in_bit = b; in_sow = s; neg_mode = m;
    @(posedge t_clk);
    @(negedge t_clk);
    for (int l = 0; l < NCH; l++) begin
      chk($sformatf("vld%0d", l), out_vld[l], v[l]);
      if (out_vld[l] && out_eow[l]) eow_cnt[l]++;
      if (v[l]) begin
        if (s[l] || mk[l] == 0) begin
          mk[l] = 0; mp[l] = 0; mmode[l] = m[l]; obs[l] = '0;
        end
        mp[l] = mp[l] | (longint'(b[l]) << mk[l]);
        nv = 64'd0 - mp[l];
        eb = mmode[l] ? nv[mk[l]] : b[l];
        ee = (mk[l] == W - 1);
        eo = ee && mmode[l] && (mp[l] == (64'd1 << (W - 1)));
        chk($sformatf("bit%0d", l), out_bit[l], eb);
        chk($sformatf("eow%0d", l), out_eow[l], ee);
        chk($sformatf("ovf%0d", l), ovf[l], eo);
        obs[l][mk[l]] = out_bit[l];
        if (ee) begin
          last_word[l] = obs[l];
          last_ovf[l] = ovf[l];
        end
        mk[l] = ee ? 0 : mk[l] + 1;
      end
    end
  endtask

  task automatic feed(input int l, input logic [W-1:0] w, input logic mode);
    logic [NCH-1:0] v, b, m;
    for (int i = 0; i < W; i++) begin
      v = '0; b = '0; m = '0;
      v[l] = 1'b1; b[l] = w[i]; m[l] = mode;
      step(v, b, '0, m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0);
  endtask

  initial begin
    logic [W-1:0]   w0, w1;
    logic [NCH-1:0] v, b, s, m;
    int unsigned    e0;

    r = 1'b0; in_vld = '0; in_bit = '0; in_sow = '0; neg_mode = '0;
    model_reset();
    for (int l = 0; l < NCH; l++) begin
      eow_cnt[l] = 0; obs[l] = '0; last_word[l] = '0; last_ovf[l] = 1'b0;
    end
    repeat (2) @(negedge t_clk);
    chk("rst_vld", out_vld, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_eow", out_eow, 0);
    chk("rst_ovf", ovf, 0);
    r = 1'b1;
    idle(1);

    feed(0, 8'h06, 1'b1);
    chk("neg06", last_word[0], 8'hFA);
    chk("neg06_ovf", last_ovf[0], 0);
    feed(0, 8'h80, 1'b1);
    chk("neg80", last_word[0], 8'h80);
    chk("neg80_ovf", last_ovf[0], 1);
    feed(0, 8'h00, 1'b1);
    chk("neg00", last_word[0], 8'h00);
    chk("neg00_ovf", last_ovf[0], 0);

    w0 = 8'h01; w1 = 8'h35;
    for (int i = 0; i < W; i++) begin
      b = '0; b[0] = w0[i]; b[1] = w1[i];
      step(4'b0011, b, '0, 4'b0001);
    end
    chk("conc_l0", last_word[0], 8'hFF);
    chk("conc_l1", last_word[1], 8'h35);

    w0 = 8'h0C;
    for (int i = 0; i < W; i++) begin
      b = '0; b[0] = w0[i];
      step(4'b0001, b, '0, 4'b0001);
      if (i == 2 || i == 5) idle(3);
    end
    chk("gap0C", last_word[0], 8'hF4);

    e0 = eow_cnt[0];
    w0 = 8'h55;
    for (int i = 0; i < 4; i++) begin
      b = '0; b[0] = w0[i];
      step(4'b0001, b, '0, 4'b0001);
    end
    w0 = 8'h01;
    for (int i = 0; i < W; i++) begin
      b = '0; b[0] = w0[i]; s = '0; s[0] = (i == 0);
      step(4'b0001, b, s, 4'b0001);
    end
    chk("sow_eows", eow_cnt[0] - e0, 1);
    chk("sow01", last_word[0], 8'hFF);
    feed(0, 8'hFF, 1'b1);
    chk("sow_next", last_word[0], 8'h01);
    chk("sow_eows2", eow_cnt[0] - e0, 2);

    e0 = eow_cnt[0];
    w0 = 8'h02;
    for (int i = 0; i < 3; i++) begin
      b = '0; b[0] = w0[i];
      step(4'b1111, b, '0, 4'b1111);
    end
    #2 r = 1'b0;
    #1;
    chk("arst_vld", out_vld, 0);
    chk("arst_bit", out_bit, 0);
    chk("arst_eow", out_eow, 0);
    chk("arst_ovf", ovf, 0);
    in_vld = '0;
    model_reset();
    @(negedge t_clk);
    r = 1'b1;
    idle(1);
    chk("arst_noeow", eow_cnt[0], e0);
    v = 4'b0001; m = 4'b0001;
    for (int i = 0; i < W; i++) begin
      b = '0; b[0] = w0[i];
      step(v, b, '0, m);
`ifdef SERCOMP_PAR_OUT_EN
      chk("par_vld", par_vld[0], (i == W - 1));
`endif
    end
    chk("post_rst02", last_word[0], 8'hFE);
`ifdef SERCOMP_PAR_OUT_EN
    chk("par_word", par_word[W-1:0], 8'hFE);
`endif

    for (int c = 0; c < 500; c++) begin
      for (int l = 0; l < NCH; l++) begin
        v[l] = ($urandom_range(0, 3) != 0);
        b[l] = 1'($urandom);
        s[l] = ($urandom_range(0, 19) == 0);
        m[l] = ($urandom_range(0, 3) != 0);
      end
      step(v, b, s, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

endmodule
